// File: rtl/sort_array_loader_if.sv
// Input stream bundle for sort_array_loader: valid/ready beats carrying one word,
// with a last flag on the final beat of each frame.
interface sort_array_loader_if #(
    parameter int WORD_SIZE = 16
);
    logic                 valid;
    logic [WORD_SIZE-1:0] data;
    logic                 last;
    logic                 ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/sort_array_loader.sv
// Stream-to-array front end for quick_sort: loads a frame into REG[0..N-1], pulses start
// with lo=0/hi=N-1 and blocks input until sort_done. Optional SORT_LOADER_CHECKSUM_EN adds o_checksum.
//
// state   | meaning
// S_IDLE  | ready for first beat of a frame
// S_LOAD  | writing beats at consecutive addresses
// S_DRAIN | array full, discarding beats until last
// S_START | frame complete, start pulse issued next cycle
// S_WAIT  | sorter running, input held off until sort_done
module sort_array_loader #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 10,
    parameter int ADDR_W    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sort_array_loader_if.slave   s_in,
    output logic                 o_wr_en,
    output logic [ADDR_W-1:0]    o_wr_addr,
    output logic [WORD_SIZE-1:0] o_wr_data,
    output logic                 o_start,
    output logic [WORD_SIZE-1:0] o_lo,
    output logic [WORD_SIZE-1:0] o_hi,
    input  logic                 i_sort_done,
    output logic                 o_busy,
    output logic                 o_overflow
`ifdef SORT_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_SIZE-1:0] o_checksum
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_START,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_count;
    logic                 r_in_ready;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [WORD_SIZE-1:0] r_wr_data;
    logic                 r_start;
    logic [WORD_SIZE-1:0] r_hi;
    logic                 r_busy;
    logic                 r_overflow;
    logic                 w_accept;
    logic                 w_write;
    logic                 w_first;
    logic                 w_set_ovf;

    assign w_accept = s_in.valid && r_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_write      = 1'b0;
        w_first      = 1'b0;
        w_set_ovf    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    w_first = 1'b1;
                    if (s_in.last) begin
                        w_next_state = S_START;
                    end else if (DEPTH == 1) begin
                        w_next_state = S_DRAIN;
                        w_set_ovf    = 1'b1;
                    end else begin
                        w_next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (s_in.last) begin
                        w_next_state = S_START;
                    end else if (r_count == LAST_IDX) begin
                        w_next_state = S_DRAIN;
                        w_set_ovf    = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (w_accept && s_in.last) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_sort_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Handshake/status flops look at the next state so they line up with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_start    <= 1'b0;
            r_hi       <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == S_IDLE) || (w_next_state == S_LOAD) ||
                          (w_next_state == S_DRAIN);
            r_busy     <= (w_next_state != S_IDLE);
            r_wr_en    <= w_write;
            if (w_write) begin
                r_wr_addr <= w_first ? '0 : r_count[ADDR_W-1:0];
                r_wr_data <= s_in.data;
                r_count   <= w_first ? CNT_W'(1) : r_count + 1'b1;
            end
            if (w_first) begin
                r_overflow <= 1'b0;
            end
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            // Pulse lands one cycle after the last array write.
            r_start <= (r_state == S_START);
            if (r_state == S_START) begin
                r_hi <= WORD_SIZE'(r_count - 1'b1);
            end
        end
    end

`ifdef SORT_LOADER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if (w_write) begin
            r_checksum <= w_first ? s_in.data : r_checksum + s_in.data;
        end
    end

    assign o_checksum = r_checksum;
`else
    // Without the checksum option no accumulator is built.
`endif

    assign s_in.ready = r_in_ready;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_start    = r_start;
    assign o_lo       = '0;
    assign o_hi       = r_hi;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_sort_array_loader.sv
// Randomized bench for sort_array_loader: frames are compared against a queue model of
// what the array should hold, where start lands, and the hi/overflow results.
module tb_sort_array_loader;

    localparam int WS    = 16;
    localparam int DEPTH = 10;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WS-1:0] wr_data;
    logic          start;
    logic [WS-1:0] lo;
    logic [WS-1:0] hi;
    logic          sort_done;
    logic          busy;
    logic          overflow;
`ifdef SORT_LOADER_CHECKSUM_EN
    logic [WS-1:0] checksum;
`endif

    sort_array_loader_if #(.WORD_SIZE(WS)) u_if ();

    sort_array_loader #(.WORD_SIZE(WS), .DEPTH(DEPTH), .ADDR_W(AW)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .s_in        (u_if.slave),
        .o_wr_en     (wr_en),
        .o_wr_addr   (wr_addr),
        .o_wr_data   (wr_data),
        .o_start     (start),
        .o_lo        (lo),
        .o_hi        (hi),
        .i_sort_done (sort_done),
        .o_busy      (busy),
        .o_overflow  (overflow)
`ifdef SORT_LOADER_CHECKSUM_EN
        ,
        .o_checksum  (checksum)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_wr_cyc = 0;

    logic [AW-1:0] wq_addr[$];
    logic [WS-1:0] wq_data[$];
    logic [WS-1:0] sq_hi[$];
    logic [WS-1:0] sq_lo[$];
    int            sq_gap[$];
    logic [WS-1:0] frame_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
                last_wr_cyc = cyc;
            end
            if (start) begin
                sq_hi.push_back(hi);
                sq_lo.push_back(lo);
                sq_gap.push_back(cyc - last_wr_cyc);
            end
        end
    end

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        sq_hi.delete();
        sq_lo.delete();
        sq_gap.delete();
    endtask

    task automatic drive_beat(input logic [WS-1:0] d, input logic lst, output int waits);
        waits = 0;
        u_if.valid = 1'b1;
        u_if.data  = d;
        u_if.last  = lst;
        @(negedge clk);
        while (!u_if.ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!u_if.ready) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", u_if.ready, waits);
        end
        @(posedge clk);
        #1;
        u_if.valid = 1'b0;
        u_if.last  = 1'b0;
        u_if.data  = WS'($urandom_range(65535));
    endtask

    // Loads frame_q, checks array writes and start against the model, then releases the sorter.
    task automatic run_frame(input string name, input int gap_pct, input bit b2b, input bit sd_in_load);
        int n;
        int exp_n;
        int waits;
        int guard;
        logic [WS-1:0] exp_sum;
        n = frame_q.size();
        exp_n = (n < DEPTH) ? n : DEPTH;
        clear_mon();
        for (int i = 0; i < n; i++) begin
            if (sd_in_load && i == 1) sort_done = 1'b1;
            drive_beat(frame_q[i], (i == n - 1), waits);
            sort_done = 1'b0;
            if (b2b && i == 0) begin
                checks++;
                if (waits !== 0) begin
                    failures++;
                    $display("FAIL %s b2b_first_beat: waited %0d cycles, required 0", name, waits);
                end
            end
            if (i != n - 1 && $urandom_range(99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
        end
        guard = 0;
        while (sq_hi.size() == 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sq_hi.size() == 0) begin
            failures++;
            $display("FAIL %s start_seen: no start within %0d cycles", name, guard);
        end
        for (int k = 0; k < 5; k++) @(negedge clk);
        checks++;
        if (sq_hi.size() !== 1) begin
            failures++;
            $display("FAIL %s start_pulses: got %0d, required 1", name, sq_hi.size());
        end
        checks++;
        if (u_if.ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s hold_off: in_ready=%0b busy=%0b, required 0/1", name, u_if.ready, busy);
        end
        checks++;
        if (wq_addr.size() !== exp_n) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wq_addr.size(), exp_n);
        end
        exp_sum = '0;
        for (int i = 0; i < exp_n && i < wq_addr.size(); i++) begin
            exp_sum = exp_sum + frame_q[i];
            checks++;
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== frame_q[i]) begin
                failures++;
                $display("FAIL %s write[%0d]: addr=%0d data=%0d, required addr=%0d data=%0d",
                         name, i, wq_addr[i], wq_data[i], i, frame_q[i]);
            end
        end
        if (sq_hi.size() > 0) begin
            checks++;
            if (sq_hi[0] !== WS'(exp_n - 1) || sq_lo[0] !== '0) begin
                failures++;
                $display("FAIL %s lo_hi: lo=%0d hi=%0d, required lo=0 hi=%0d", name, sq_lo[0], sq_hi[0], exp_n - 1);
            end
            if (n <= DEPTH) begin
                checks++;
                if (sq_gap[0] !== 1) begin
                    failures++;
                    $display("FAIL %s start_latency: %0d cycles after last write, required 1", name, sq_gap[0]);
                end
            end
        end
        checks++;
        if (overflow !== (n > DEPTH)) begin
            failures++;
            $display("FAIL %s overflow: got %0b, required %0b", name, overflow, (n > DEPTH));
        end
`ifdef SORT_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== exp_sum) begin
            failures++;
            $display("FAIL %s checksum: got %0d, required %0d", name, checksum, exp_sum);
        end
`endif
        @(posedge clk);
        #1;
        sort_done = 1'b1;
        @(posedge clk);
        #1;
        sort_done = 1'b0;
        checks++;
        if (u_if.ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s release: in_ready=%0b busy=%0b, required 1/0", name, u_if.ready, busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (u_if.ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
            start !== 1'b0 || lo !== '0 || hi !== '0 || busy !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s reset_outputs: rdy=%0b wr_en=%0b addr=%0d data=%0d start=%0b lo=%0d hi=%0d busy=%0b ovf=%0b, required 1 0 0 0 0 0 0 0 0",
                     name, u_if.ready, wr_en, wr_addr, wr_data, start, lo, hi, busy, overflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("test_reset");
    endtask

    task automatic test_known_frame();
        frame_q = '{16'd55, 16'd8, 16'd34, 16'd6, 16'd5, 16'd22, 16'd33, 16'd2, 16'd1, 16'd13};
        run_frame("known_frame", 0, 1'b0, 1'b0);
    endtask

    task automatic test_single_word();
        frame_q = '{16'd7};
        run_frame("single_word", 0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        frame_q.delete();
        for (int i = 0; i < 12; i++) frame_q.push_back(WS'($urandom_range(65535)));
        run_frame("overflow", 0, 1'b0, 1'b0);
    endtask

    task automatic test_valid_toggle();
        frame_q.delete();
        for (int i = 0; i < 4; i++) frame_q.push_back(WS'($urandom_range(65535)));
        run_frame("valid_toggle", 100, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int waits;
        for (int i = 0; i < 3; i++) drive_beat(WS'($urandom_range(65535)), 1'b0, waits);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset_mid_frame");
        clear_mon();
        repeat (10) @(negedge clk);
        checks++;
        if (sq_hi.size() !== 0 || wq_addr.size() !== 0) begin
            failures++;
            $display("FAIL reset_mid_frame no_start: starts=%0d writes=%0d, required 0/0", sq_hi.size(), wq_addr.size());
        end
        @(posedge clk);
        #1;
        frame_q = '{16'd300, 16'd17};
        run_frame("after_reset", 0, 1'b0, 1'b0);
    endtask

    task automatic test_sort_done_in_load();
        frame_q.delete();
        for (int i = 0; i < 5; i++) frame_q.push_back(WS'($urandom_range(65535)));
        run_frame("sort_done_in_load", 0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        frame_q = '{16'd9, 16'd4, 16'd1};
        run_frame("b2b_first", 0, 1'b0, 1'b0);
        frame_q = '{16'd1000, 16'd2, 16'd65535, 16'd3};
        run_frame("b2b_second", 0, 1'b1, 1'b0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(13, 1);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(WS'($urandom_range(65535)));
            run_frame($sformatf("random_%0d_len%0d", f, n), $urandom_range(60), 1'($urandom_range(1)), 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        sort_done  = 1'b0;
        u_if.valid = 1'b0;
        u_if.data  = '0;
        u_if.last  = 1'b0;
        test_reset();
        test_known_frame();
        test_single_word();
        test_overflow();
        test_valid_toggle();
        test_reset_mid_frame();
        test_sort_done_in_load();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
